dispatch_router: RTL and testbench
==================================

Name: dispatch_router

Overview:
- Sits directly downstream of the in-order instruction queue.
- Pops one instruction at a time, holds it in a single-entry dispatch register, and presents it to exactly one functional-unit reservation station, selected by its funcUnitType code, using a valid/ready handshake.
- Also drops instructions with illegal unit codes, supports a pipeline flush, and keeps dispatch/stall statistics.

Parameters:
- PAYLOAD_WIDTH, 305: packed instruction fields other than funcUnitType. Packing order: format 25, opcode 12, address 64, majID 64, minID 7, is64Bit 1, pid 20, tid 16, operandRW 8, operandIsReg 4, body 84.
- FUNC_UNIT_CODE_SIZE, 3: width of the unit code.
- NUM_UNITS, 8: 2**FUNC_UNIT_CODE_SIZE, the number of unit slots.
- UNIT_MASK, 8'b11111010: bit u=1 means unit code u exists. MSB-first: bit[0]=FX, bit[1]=FP, bit[2]=VX, bit[3]=CR, bit[4]=LS, bit[6]=Branch.
- COUNT_WIDTH, 32: width of the statistics counters.

Ports:
- clock_i, in, 1: single clock. All state updates on the rising edge.
- reset_i, in, 1: asynchronous, active-low reset.
- flush_i, in, 1: synchronous flush; discards the held or in-flight instruction.
- queueEmpty_i, in, 1: queue isEmpty_o.
- queueRead_o, out, 1: queue readEnable_i; one pop per asserted cycle.
- queueFuncUnit_i, in, FUNC_UNIT_CODE_SIZE: queue funcUnitType_o. Valid the cycle after queueRead_o.
- queuePayload_i, in, PAYLOAD_WIDTH: the other queue outputs, packed. Valid the cycle after queueRead_o.
- unitValid_o, out, NUM_UNITS: one-hot; bit u requests unit u.
- unitReady_i, in, NUM_UNITS: bit u means unit u accepts this cycle.
- funcUnit_o, out, FUNC_UNIT_CODE_SIZE: unit code of the held instruction.
- payload_o, out, PAYLOAD_WIDTH: held payload.
- dispatchCount_o, out, COUNT_WIDTH: count of accepted instructions. Saturates.
- stallCycles_o, out, COUNT_WIDTH: cycles spent with valid high and ready low. Saturates.
- illegalUnit_o, out, 1: sticky; set when an instruction with an illegal unit code is dropped.

Behaviour:
- Reset (reset_i=0, asynchronous):
  - state=EMPTY.
  - All outputs 0, including the counters and illegalUnit_o.
  - Takes effect mid-operation: an in-flight read is abandoned and its data is never captured.
- States: EMPTY (nothing held), READ (pop issued, data arrives this cycle), HOLD (instruction held, valid asserted).
- queueRead_o is combinational. It is high when flush_i=0, queueEmpty_i=0, and either:
  - state=EMPTY, or
  - state=HOLD and the held instruction is accepted this cycle.
- Transitions:
  - EMPTY: queueRead_o=1 -> READ, else stay EMPTY.
  - READ: capture queueFuncUnit_i/queuePayload_i at the edge.
    - If UNIT_MASK[code]=1 -> HOLD.
    - Otherwise set illegalUnit_o, discard the data -> EMPTY.
  - HOLD: unitValid_o[funcUnit_o]=1, all other bits 0.
    - Accept = unitReady_i[funcUnit_o] in the same cycle.
    - Accept with queueRead_o=1 -> READ.
    - Accept with queue empty -> EMPTY.
    - No accept -> stay HOLD; payload_o and funcUnit_o stay stable.
- Ready on non-selected units is ignored. unitValid_o never depends combinationally on unitReady_i.
- Latency: 2 cycles from the queueRead_o cycle to unitValid_o high. Peak throughput is 1 instruction per 2 cycles.
- flush_i=1 (priority over everything except reset):
  - Next state EMPTY; unitValid_o is forced 0 in that cycle; queueRead_o=0.
  - If in READ, the arriving data is dropped and illegalUnit_o is not updated.
  - A handshake is not counted in a flush cycle.
- Counters:
  - dispatchCount_o increments on each accept.
  - stallCycles_o increments on each HOLD cycle with no accept and no flush.
  - Both saturate at all-ones; no wrap.
- payload_o and funcUnit_o hold their last value when not in HOLD; consumers must qualify with unitValid_o.
- Upstream rule: queueRead_o is never asserted while queueEmpty_i=1, so the block never underflows the queue.

Test Plan:
- Reset, then load queue with FX (code 0) and FP (code 1) entries, all ready=1:
  - Cycle 1 queueRead_o=1.
  - Cycle 3 unitValid_o=8'b10000000 with payload A.
  - Cycle 5 unitValid_o=8'b01000000.
  - Final dispatchCount_o=2, queue empty, state EMPTY.
- Back-pressure: LS (code 4) entry held with unitReady_i[4]=0 for 5 cycles, then 1:
  - payload_o stable throughout; stallCycles_o=5; dispatchCount_o=1.
  - Ready on other units during the stall has no effect.
- Illegal code: enqueue code 5, then code 6:
  - Code 5 never raises unitValid_o and illegalUnit_o=1 (stays 1).
  - Code 6 is dispatched on bit 6.
- Flush:
  - Flush in READ: captured data discarded, no unitValid_o.
  - Flush in HOLD: unitValid_o=0 that cycle, state EMPTY, dispatchCount_o unchanged.
- Queue full of 8 entries, all ready=1 -> 8 dispatches over 16 cycles in queue order by majID 0..7; queueRead_o never high while queueEmpty_i=1.
- Asynchronous reset asserted mid-HOLD between clock edges -> unitValid_o, queueRead_o, counters and illegalUnit_o are 0 immediately, before the next clock edge.

Source files
------------

// File: rtl/dispatch_router.sv
// dispatch_router: pops one instruction at a time from the in-order
// instruction queue, holds it in a single-entry dispatch register and offers
// it to the one reservation station named by its unit code (valid/ready).
// Instructions whose unit code is not populated are dropped and flagged.
//
// Unit vectors (UNIT_MASK, unitValid_o, unitReady_i) are indexed [0:NUM_UNITS-1]
// so that element u is unit code u and element 0 is the MSB of a literal.
//
// Ports:
//   clock_i, reset_i          clock, async active-low reset
//   flush_i                   synchronous flush of held / in-flight entry
//   queueEmpty_i              queue empty flag
//   queueRead_o               queue pop strobe (combinational)
//   queueFuncUnit_i           unit code, valid the cycle after a pop
//   queuePayload_i            packed instruction payload, same timing
//   unitValid_o               one-hot request to the selected unit
//   unitReady_i               per-unit accept
//   funcUnit_o, payload_o     held instruction
//   dispatchCount_o           saturating accepted-instruction count
//   stallCycles_o             saturating valid-without-ready cycle count
//   illegalUnit_o             sticky illegal-unit-code drop flag

module dispatch_router #(
  parameter int unsigned PAYLOAD_WIDTH       = 305,
  parameter int unsigned FUNC_UNIT_CODE_SIZE = 3,
  parameter int unsigned NUM_UNITS           = 2 ** FUNC_UNIT_CODE_SIZE,
  parameter logic [0:NUM_UNITS-1] UNIT_MASK  = 8'b11111010,
  parameter int unsigned COUNT_WIDTH         = 32
) (
  input  logic                           clock_i,
  input  logic                           reset_i,
  input  logic                           flush_i,
  input  logic                           queueEmpty_i,
  output logic                           queueRead_o,
  input  logic [FUNC_UNIT_CODE_SIZE-1:0] queueFuncUnit_i,
  input  logic [PAYLOAD_WIDTH-1:0]       queuePayload_i,
  output logic [0:NUM_UNITS-1]           unitValid_o,
  input  logic [0:NUM_UNITS-1]           unitReady_i,
  output logic [FUNC_UNIT_CODE_SIZE-1:0] funcUnit_o,
  output logic [PAYLOAD_WIDTH-1:0]       payload_o,
  output logic [COUNT_WIDTH-1:0]         dispatchCount_o,
  output logic [COUNT_WIDTH-1:0]         stallCycles_o,
  output logic                           illegalUnit_o
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_READ  = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  state_e                           state_q, state_d;
  logic [FUNC_UNIT_CODE_SIZE-1:0]   func_unit_q, func_unit_d;
  logic [PAYLOAD_WIDTH-1:0]         payload_q, payload_d;
  logic [COUNT_WIDTH-1:0]           dispatch_cnt_q, dispatch_cnt_d;
  logic [COUNT_WIDTH-1:0]           stall_cnt_q, stall_cnt_d;
  logic                             illegal_q, illegal_d;

  logic                             hold_c;
  logic                             sel_ready_c;
  logic                             accept_c;
  logic                             stall_c;
  logic                             pop_c;
  logic                             legal_c;
  logic [0:NUM_UNITS-1]             valid_c;

  // Handshake decode; flush kills both the offer and any new pop.
  always_comb begin
    hold_c      = (state_q == ST_HOLD);
    sel_ready_c = unitReady_i[func_unit_q];
    accept_c    = hold_c && !flush_i && sel_ready_c;
    stall_c     = hold_c && !flush_i && !sel_ready_c;
    legal_c     = UNIT_MASK[queueFuncUnit_i];
    pop_c       = !flush_i && !queueEmpty_i &&
                  ((state_q == ST_EMPTY) || accept_c);
  end

  // Pop strobe is also gated by reset so it drops the instant reset asserts;
  // the ungated pop_c feeds the state logic to keep reset off the D paths.
  assign queueRead_o = pop_c && reset_i;

  // One-hot request decoded from the held code only, never from ready.
  always_comb begin
    valid_c = '0;
    if (hold_c && !flush_i) begin
      valid_c[func_unit_q] = 1'b1;
    end
  end

  assign unitValid_o = valid_c;

  // Next-state, capture and statistics.
  always_comb begin
    state_d        = state_q;
    func_unit_d    = func_unit_q;
    payload_d      = payload_q;
    illegal_d      = illegal_q;
    dispatch_cnt_d = dispatch_cnt_q;
    stall_cnt_d    = stall_cnt_q;

    if (flush_i) begin
      state_d = ST_EMPTY;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (pop_c) state_d = ST_READ;
        end
        ST_READ: begin
          if (legal_c) begin
            func_unit_d = queueFuncUnit_i;
            payload_d   = queuePayload_i;
            state_d     = ST_HOLD;
          end else begin
            illegal_d = 1'b1;
            state_d   = ST_EMPTY;
          end
        end
        ST_HOLD: begin
          if (accept_c) begin
            state_d = pop_c ? ST_READ : ST_EMPTY;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end

    // Counters saturate at all-ones rather than wrapping.
    if (accept_c && (dispatch_cnt_q != '1)) begin
      dispatch_cnt_d = dispatch_cnt_q + COUNT_WIDTH'(1);
    end
    if (stall_c && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + COUNT_WIDTH'(1);
    end
  end

  // State and output registers.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q        <= ST_EMPTY;
      func_unit_q    <= '0;
      payload_q      <= '0;
      illegal_q      <= 1'b0;
      dispatch_cnt_q <= '0;
      stall_cnt_q    <= '0;
    end else begin
      state_q        <= state_d;
      func_unit_q    <= func_unit_d;
      payload_q      <= payload_d;
      illegal_q      <= illegal_d;
      dispatch_cnt_q <= dispatch_cnt_d;
      stall_cnt_q    <= stall_cnt_d;
    end
  end

  assign funcUnit_o      = func_unit_q;
  assign payload_o       = payload_q;
  assign dispatchCount_o = dispatch_cnt_q;
  assign stallCycles_o   = stall_cnt_q;
  assign illegalUnit_o   = illegal_q;

endmodule

// File: tb/tb_dispatch_router.sv
// Directed bench for dispatch_router with a small in-order queue model.
// Inputs change 1 time unit after the rising edge; outputs are sampled on
// the falling edge.

module tb_dispatch_router;

  localparam int unsigned PW = 305;
  localparam int unsigned CS = 3;
  localparam int unsigned NU = 8;
  localparam int unsigned CW = 32;
  localparam int unsigned XW = 320;

  typedef struct {
    logic [CS-1:0] func;
    logic [PW-1:0] pay;
  } ent_t;

  logic          clock_i;
  logic          reset_i;
  logic          flush_i;
  logic          queueEmpty_i;
  logic          queueRead_o;
  logic [CS-1:0] queueFuncUnit_i;
  logic [PW-1:0] queuePayload_i;
  logic [0:NU-1] unitValid_o;
  logic [0:NU-1] unitReady_i;
  logic [CS-1:0] funcUnit_o;
  logic [PW-1:0] payload_o;
  logic [CW-1:0] dispatchCount_o;
  logic [CW-1:0] stallCycles_o;
  logic          illegalUnit_o;

  dispatch_router dut (
    .clock_i         (clock_i),
    .reset_i         (reset_i),
    .flush_i         (flush_i),
    .queueEmpty_i    (queueEmpty_i),
    .queueRead_o     (queueRead_o),
    .queueFuncUnit_i (queueFuncUnit_i),
    .queuePayload_i  (queuePayload_i),
    .unitValid_o     (unitValid_o),
    .unitReady_i     (unitReady_i),
    .funcUnit_o      (funcUnit_o),
    .payload_o       (payload_o),
    .dispatchCount_o (dispatchCount_o),
    .stallCycles_o   (stallCycles_o),
    .illegalUnit_o   (illegalUnit_o)
  );

  initial begin
    clock_i = 1'b0;
    forever #5 clock_i = ~clock_i;
  end

  ent_t          q[$];
  int            n_vec;
  int            n_bad;
  int            rd_viol;
  logic          o_rd;
  logic [0:NU-1] o_valid;
  logic [CS-1:0] o_func;
  logic [PW-1:0] o_pay;
  logic [CW-1:0] o_cnt;
  logic [CW-1:0] o_stall;
  logic          o_ill;

  task automatic chk(input string tag, input logic [XW-1:0] got,
                     input logic [XW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Payload with majID in its field, other fields derived from the id.
  function automatic logic [PW-1:0] mk_pay(input int id);
    logic [PW-1:0] p;
    logic [3:0]    nib;
    p          = '0;
    nib        = 4'(id);
    p[203:140] = 64'(id);
    p[304:280] = 25'h15A5A5 ^ 25'(id);
    p[83:0]    = {21{nib}};
    return p;
  endfunction

  task automatic push(input int code, input int id);
    ent_t e;
    e.func = CS'(code);
    e.pay  = mk_pay(id);
    q.push_back(e);
    queueEmpty_i = 1'b0;
  endtask

  // One clock cycle: sample outputs at the falling edge, then model the
  // queue pop that the sampled read strobe causes at the rising edge.
  task automatic step();
    ent_t e;
    @(negedge clock_i);
    o_rd    = queueRead_o;
    o_valid = unitValid_o;
    o_func  = funcUnit_o;
    o_pay   = payload_o;
    o_cnt   = dispatchCount_o;
    o_stall = stallCycles_o;
    o_ill   = illegalUnit_o;
    if (o_rd && queueEmpty_i) rd_viol++;
    @(posedge clock_i);
    #1;
    if (o_rd && (q.size() > 0)) begin
      e               = q.pop_front();
      queueFuncUnit_i = e.func;
      queuePayload_i  = e.pay;
    end
    queueEmpty_i = (q.size() == 0);
  endtask

  task automatic do_reset();
    reset_i      = 1'b0;
    q.delete();
    queueEmpty_i = 1'b1;
    flush_i      = 1'b0;
    unitReady_i  = '1;
    @(posedge clock_i);
    #1;
    reset_i = 1'b1;
  endtask

  logic [CS-1:0] codes [8];
  logic [0:NU-1] exp_v;

  initial begin
    n_vec = 0; n_bad = 0; rd_viol = 0;
    reset_i = 1'b0; flush_i = 1'b0; queueEmpty_i = 1'b1;
    queueFuncUnit_i = '0; queuePayload_i = '0; unitReady_i = '1;
    codes[0] = 3'd0; codes[1] = 3'd1; codes[2] = 3'd2; codes[3] = 3'd3;
    codes[4] = 3'd4; codes[5] = 3'd6; codes[6] = 3'd0; codes[7] = 3'd1;

    // Reset state before any clock edge
    #2;
    chk("rst_valid", XW'(unitValid_o), XW'(8'b00000000));
    chk("rst_read", XW'(queueRead_o), XW'(1'b0));
    chk("rst_cnt", XW'(dispatchCount_o), XW'(0));
    chk("rst_stall", XW'(stallCycles_o), XW'(0));
    chk("rst_ill", XW'(illegalUnit_o), XW'(1'b0));
    chk("rst_pay", XW'(payload_o), XW'(0));
    @(posedge clock_i); #1;
    reset_i = 1'b1;

    // Basic FX then FP, all ready
    push(0, 1); push(1, 2);
    step(); chk("b_c1_read", XW'(o_rd), XW'(1'b1));
            chk("b_c1_valid", XW'(o_valid), XW'(8'b00000000));
    step(); chk("b_c2_read", XW'(o_rd), XW'(1'b0));
    step(); chk("b_c3_valid", XW'(o_valid), XW'(8'b10000000));
            chk("b_c3_pay", XW'(o_pay), XW'(mk_pay(1)));
            chk("b_c3_read", XW'(o_rd), XW'(1'b1));
    step(); chk("b_c4_valid", XW'(o_valid), XW'(8'b00000000));
    step(); chk("b_c5_valid", XW'(o_valid), XW'(8'b01000000));
            chk("b_c5_pay", XW'(o_pay), XW'(mk_pay(2)));
            chk("b_c5_read", XW'(o_rd), XW'(1'b0));
    step(); chk("b_c6_cnt", XW'(o_cnt), XW'(2));
            chk("b_c6_valid", XW'(o_valid), XW'(8'b00000000));

    // Back-pressure on LS; other units ready
    do_reset();
    push(4, 20);
    step(); step();
    unitReady_i = 8'b11110111;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_valid", XW'(o_valid), XW'(8'b00001000));
      chk("bp_pay", XW'(o_pay), XW'(mk_pay(20)));
    end
    unitReady_i = '1;
    step(); chk("bp_acc_valid", XW'(o_valid), XW'(8'b00001000));
            chk("bp_acc_read", XW'(o_rd), XW'(1'b0));
    step(); chk("bp_stall", XW'(o_stall), XW'(5));
            chk("bp_cnt", XW'(o_cnt), XW'(1));
            chk("bp_valid_end", XW'(o_valid), XW'(8'b00000000));

    // Illegal code 5 dropped, code 6 dispatched
    do_reset();
    push(5, 30); push(6, 31);
    step(); chk("il_c1_read", XW'(o_rd), XW'(1'b1));
    step(); chk("il_c2_valid", XW'(o_valid), XW'(8'b00000000));
    step(); chk("il_c3_valid", XW'(o_valid), XW'(8'b00000000));
            chk("il_c3_ill", XW'(o_ill), XW'(1'b1));
            chk("il_c3_read", XW'(o_rd), XW'(1'b1));
    step(); chk("il_c4_valid", XW'(o_valid), XW'(8'b00000000));
    step(); chk("il_c5_valid", XW'(o_valid), XW'(8'b00000010));
            chk("il_c5_pay", XW'(o_pay), XW'(mk_pay(31)));
    step(); chk("il_c6_ill", XW'(o_ill), XW'(1'b1));
            chk("il_c6_cnt", XW'(o_cnt), XW'(1));

    // Flush while in READ
    do_reset();
    push(0, 40);
    step();
    flush_i = 1'b1;
    step(); chk("fr_read", XW'(o_rd), XW'(1'b0));
    flush_i = 1'b0;
    step(); chk("fr_c3_valid", XW'(o_valid), XW'(8'b00000000));
    step(); chk("fr_c4_valid", XW'(o_valid), XW'(8'b00000000));
            chk("fr_pay", XW'(o_pay), XW'(0));
            chk("fr_ill", XW'(o_ill), XW'(1'b0));

    // Flush while in HOLD
    push(1, 41); push(0, 42);
    step(); step();
    flush_i = 1'b1;
    step(); chk("fh_valid", XW'(o_valid), XW'(8'b00000000));
            chk("fh_read", XW'(o_rd), XW'(1'b0));
    flush_i = 1'b0;
    step(); chk("fh_cnt", XW'(o_cnt), XW'(0));
            chk("fh_c4_read", XW'(o_rd), XW'(1'b1));
            chk("fh_c4_valid", XW'(o_valid), XW'(8'b00000000));
    step();
    step(); chk("fh_c6_valid", XW'(o_valid), XW'(8'b10000000));
            chk("fh_c6_pay", XW'(o_pay), XW'(mk_pay(42)));
    step(); chk("fh_c7_cnt", XW'(o_cnt), XW'(1));

    // Eight back-to-back entries, in order
    do_reset();
    for (int i = 0; i < 8; i++) push(int'(codes[i]), i);
    for (int cyc = 1; cyc <= 18; cyc++) begin
      step();
      exp_v = '0;
      if ((cyc >= 3) && (cyc <= 17) && (cyc % 2 == 1)) begin
        exp_v = 8'b10000000 >> codes[(cyc - 3) / 2];
        chk("burst_majid", XW'(o_pay[203:140]), XW'((cyc - 3) / 2));
      end
      chk("burst_valid", XW'(o_valid), XW'(exp_v));
    end
    chk("burst_cnt", XW'(o_cnt), XW'(8));

    // Asynchronous reset mid-HOLD
    do_reset();
    push(5, 50); push(4, 51);
    unitReady_i = 8'b11110111;
    for (int i = 0; i < 6; i++) step();
    push(0, 52);
    #2;
    chk("ar_pre_valid", XW'(unitValid_o), XW'(8'b00001000));
    chk("ar_pre_stall", XW'(stallCycles_o), XW'(2));
    chk("ar_pre_ill", XW'(illegalUnit_o), XW'(1'b1));
    reset_i = 1'b0;
    #1;
    chk("ar_valid", XW'(unitValid_o), XW'(8'b00000000));
    chk("ar_read", XW'(queueRead_o), XW'(1'b0));
    chk("ar_stall", XW'(stallCycles_o), XW'(0));
    chk("ar_cnt", XW'(dispatchCount_o), XW'(0));
    chk("ar_ill", XW'(illegalUnit_o), XW'(1'b0));
    @(posedge clock_i); #1;
    reset_i = 1'b1;

    chk("no_read_when_empty", XW'(rd_viol), XW'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
